mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM pipeline stage, between the EX/MEM register and the MEM/WB register.
- Runs the data-memory access for the instruction held in EX/MEM, using a req/ack handshake with a variable-latency data memory.
- Stalls the upstream pipeline until the access completes.
- Presents write-back controls, the loaded data, the ALU result and the destination register to the MEM/WB register. That register has no enable, so this block sends bubbles while stalled.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT without dmem_ack before the access is aborted with bus_err. Legal range 1..255; counter is 8 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_wreg  in  1  instruction writes the register file
- ex_m2reg  in  1  instruction is a load
- ex_wmem  in  1  instruction is a store
- ex_alu_out  in  32  ALU result / memory address
- ex_store_data  in  32  store data
- ex_reg_addr  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  memory address
- dmem_wdata  out  32  write data
- dmem_ack  in  1  memory done; dmem_rdata valid this cycle
- dmem_rdata  in  32  read data
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_wreg  out  1  to MEM/WB register, write-enable input
- mem_m2reg  out  1  to MEM/WB register, mem-to-reg select
- mem_rdata  out  32  to MEM/WB register, load data
- mem_alu_out  out  32  to MEM/WB register, ALU result
- mem_reg_addr  out  5  to MEM/WB register, destination register
- bus_err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse on misaligned access (see Optional Feature)

Behaviour:
- Definition: memop = ex_valid & (ex_m2reg | ex_wmem).
- FSM states IDLE, WAIT, DONE. Reset: state=IDLE, counter=0, rdata_q=0, err_q=0.
- IDLE:
  - memop=1 -> WAIT; mem_stall=1; WB outputs are a bubble (mem_wreg=0, mem_m2reg=0).
  - memop=0 -> stay IDLE; mem_stall=0; pass-through: mem_wreg=ex_valid&ex_wreg, mem_m2reg=0, mem_alu_out=ex_alu_out, mem_reg_addr=ex_reg_addr, mem_rdata=0.
- WAIT:
  - dmem_req=1, dmem_we=ex_wmem, dmem_addr={ex_alu_out[31:2],2'b00}, dmem_wdata=ex_store_data. These inputs are stable because EX/MEM is stalled.
  - mem_stall=1; WB bubble.
  - dmem_ack=1: rdata_q<=dmem_rdata, counter<=0 -> DONE. Ack in the first WAIT cycle is legal.
  - No ack: counter increments. When counter==TIMEOUT_CYCLES-1 and still no ack: err_q<=1, rdata_q<=0, counter<=0 -> DONE.
- DONE:
  - dmem_req=0, mem_stall=0; EX/MEM advances at the end of this cycle.
  - Normal completion: mem_wreg=ex_wreg, mem_m2reg=ex_m2reg, mem_rdata=rdata_q, mem_alu_out=ex_alu_out, mem_reg_addr=ex_reg_addr.
  - err_q=1: bus_err=1, mem_wreg=0.
  - err_q clears; next state IDLE unconditionally.
- Minimum memory-op latency is 3 cycles (IDLE, WAIT, DONE). Back-to-back memory ops re-enter WAIT via IDLE.
- dmem_ack outside WAIT is ignored.
- Outside WAIT: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- ex_valid=0 in IDLE: all WB outputs 0.
- rst mid-access: immediate return to IDLE, dmem_req drops asynchronously, counter cleared, any pending ack discarded. The memory must tolerate an abandoned request.
- Reset values: dmem_req, dmem_we and mem_stall are 0. With ex_valid=0 held, every other output also reads 0. Outputs are combinational from state plus registers; only rdata_q, err_q, counter and the state are flops.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a memop with ex_alu_out[1:0]!=0 issues no request and goes directly to DONE.
  - In that DONE cycle: misalign=1, mem_wreg=0, mem_rdata=0.
  - mem_stall=1 in the detect (IDLE) cycle, 0 in DONE.
- Undefined: misalign tied to 0; the low address bits are silently forced to 00 and the access proceeds normally.

Test Plan:
- Load, ex_alu_out=0x100, ex_reg_addr=5, ack on first WAIT cycle with rdata=0xDEADBEEF -> stall high 2 cycles; DONE shows mem_wreg=1, mem_m2reg=1, mem_rdata=0xDEADBEEF, mem_reg_addr=5.
- Store, addr=0x204, data=0x12345678, ack after 4 WAIT cycles -> dmem_we=1, dmem_addr=0x204, dmem_wdata=0x12345678 held for all 4 cycles; then stall releases with mem_wreg=0.
- ALU op, ex_wreg=1, ex_alu_out=0x7, ex_reg_addr=3 -> no stall, pass-through in the same cycle, dmem_req=0.
- Load with no ack, TIMEOUT_CYCLES=8 -> exactly 8 WAIT cycles, then DONE with bus_err=1 and mem_wreg=0; next cycle IDLE.
- rst asserted in the 2nd WAIT cycle of a load -> dmem_req and mem_stall fall immediately; a late ack after reset produces no writeback.
- MISALIGN_TRAP_EN defined, load at addr=0x102 -> no dmem_req, misalign=1 one cycle, mem_wreg=0. Undefined: dmem_addr=0x100 and the load completes.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs the EX/MEM data-memory access over a req/ack handshake and
// feeds MEM/WB, stalling upstream while busy. Optional MISALIGN_TRAP_EN traps misaligned ops.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_reg_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_alu_out,
  output logic [4:0]  mem_reg_addr,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        memop;
  logic        trap;
  logic        stall_raw;

  assign memop = ex_valid & (ex_m2reg | ex_wmem);

`ifdef MISALIGN_TRAP_EN
  // EX/MEM is frozen until DONE, so the same condition still identifies the trap in DONE.
  assign trap = memop & (ex_alu_out[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Reset must drop the stall at once, even while a memop sits in EX/MEM.
  assign mem_stall = stall_raw & ~rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 32'h0;
    dmem_wdata   = 32'h0;
    stall_raw    = 1'b0;
    mem_wreg     = 1'b0;
    mem_m2reg    = 1'b0;
    mem_rdata    = 32'h0;
    mem_alu_out  = 32'h0;
    mem_reg_addr = 5'h0;
    bus_err      = 1'b0;
    misalign     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trap) begin
          stall_raw = 1'b1;
          rdata_d   = 32'h0;
          err_d     = 1'b0;
          state_d   = StDone;
        end else if (memop) begin
          stall_raw = 1'b1;
          cnt_d     = 8'h0;
          state_d   = StWait;
        end else if (ex_valid) begin
          mem_wreg     = ex_wreg;
          mem_alu_out  = ex_alu_out;
          mem_reg_addr = ex_reg_addr;
        end
      end

      StWait: begin
        dmem_req   = 1'b1;
        dmem_we    = ex_wmem;
        dmem_addr  = {ex_alu_out[31:2], 2'b00};
        dmem_wdata = ex_store_data;
        stall_raw  = 1'b1;
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          cnt_d   = 8'h0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          cnt_d   = 8'h0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end

      StDone: begin
        mem_alu_out  = ex_alu_out;
        mem_reg_addr = ex_reg_addr;
        if (err_q) begin
          bus_err = 1'b1;
        end else if (trap) begin
          misalign = 1'b1;
        end else begin
          mem_wreg  = ex_wreg;
          mem_m2reg = ex_m2reg;
          mem_rdata = rdata_q;
        end
        err_d   = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
